// File: rtl/switch_debounce.sv
// switch_debounce: per-channel two-flop synchronizer, debounce filter and
// registered level, press, release and single-shot long-hold pulses.
module switch_debounce #(
    parameter int g_NUM_SW         = 4,
    parameter int g_DEBOUNCE_LIMIT = 250000,
    parameter int g_HOLD_LIMIT     = 25000000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [g_NUM_SW-1:0] i_Switch,
    output logic [g_NUM_SW-1:0] o_Switch,
    output logic [g_NUM_SW-1:0] o_Press,
    output logic [g_NUM_SW-1:0] o_Release,
    output logic [g_NUM_SW-1:0] o_Hold
);
    localparam int DW = $clog2(g_DEBOUNCE_LIMIT + 1);
    localparam int HW = $clog2(g_HOLD_LIMIT + 1);

    for (genvar n = 0; n < g_NUM_SW; n++) begin : g_ch
        logic          r_sync1, r_sync2, r_stable, r_press, r_release, r_hold, r_done;
        logic [DW-1:0] r_db_cnt;
        logic [HW-1:0] r_hold_cnt;
        logic          w_mismatch, w_accept, w_hold_fire;

        assign w_mismatch  = r_sync2 != r_stable;
        assign w_accept    = w_mismatch && (r_db_cnt == DW'(g_DEBOUNCE_LIMIT - 1));
        // The hold counter saturates at the limit once fired, so no auto-repeat.
        assign w_hold_fire = r_stable && !r_done && (r_hold_cnt == HW'(g_HOLD_LIMIT - 1));

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_stable   <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_hold     <= 1'b0;
                r_done     <= 1'b0;
                r_db_cnt   <= '0;
                r_hold_cnt <= '0;
            end else begin
                r_sync1    <= i_Switch[n];
                r_sync2    <= r_sync1;
                r_db_cnt   <= (!w_mismatch || w_accept) ? '0 : r_db_cnt + 1'b1;
                r_stable   <= w_accept ? r_sync2 : r_stable;
                r_press    <= w_accept && r_sync2;
                r_release  <= w_accept && !r_sync2;
                r_hold_cnt <= !r_stable ? '0 : (r_done ? r_hold_cnt : r_hold_cnt + 1'b1);
                r_done     <= r_stable && (r_done || w_hold_fire);
                r_hold     <= w_hold_fire;
            end
        end

        assign o_Switch[n]  = r_stable;
        assign o_Press[n]   = r_press;
        assign o_Release[n] = r_release;
        assign o_Hold[n]    = r_hold;
    end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scenarios plus randomized stimulus, checked
// every cycle against a sliding-window behavioural model of the debouncer.
module tb_switch_debounce;
    localparam int N = 4;
    localparam int L = 4;
    localparam int H = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] sw = '0;
    logic [N-1:0] o_sw, o_p, o_r, o_h;

    int tests = 0;
    int fails = 0;

    switch_debounce #(.g_NUM_SW(N), .g_DEBOUNCE_LIMIT(L), .g_HOLD_LIMIT(H)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
        .o_Switch(o_sw), .o_Press(o_p), .o_Release(o_r), .o_Hold(o_h)
    );

    always #5 clk = ~clk;

    // Model: stable flips once the last L synchronized samples all differ
    // from it; hold fires H edges after the press edge if still held.
    logic [N-1:0] m_s1, m_s2, m_stab, m_done;
    logic [L-1:0] m_win [N];
    int           m_pt [N];
    int           m_t;
    logic [N-1:0] e_sw, e_p, e_r, e_h;

    task automatic reset_model();
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_done = '0; m_t = 0;
        e_sw = '0; e_p = '0; e_r = '0; e_h = '0;
        for (int n = 0; n < N; n++) begin
            m_win[n] = '0;
            m_pt[n] = 0;
        end
    endtask

    task automatic step_model();
        logic old;
        e_p = '0; e_r = '0; e_h = '0;
        for (int n = 0; n < N; n++) begin
            old = m_stab[n];
            m_win[n] = {m_win[n][L-2:0], m_s2[n]};
            if (old && !m_done[n] && (m_t - m_pt[n] == H)) begin
                e_h[n] = 1'b1;
                m_done[n] = 1'b1;
            end
            if (m_win[n] == {L{~old}}) begin
                m_stab[n] = ~old;
                if (!old) begin
                    e_p[n] = 1'b1;
                    m_pt[n] = m_t;
                end else begin
                    e_r[n] = 1'b1;
                    m_done[n] = 1'b0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
        e_sw = m_stab;
        m_t++;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) reset_model();
            else step_model();
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_switch", 32'(o_sw), 32'(e_sw));
            chk("model_press", 32'(o_p), 32'(e_p));
            chk("model_release", 32'(o_r), 32'(e_r));
            chk("model_hold", 32'(o_h), 32'(e_h));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    int cnt_h, cnt_r, first_h;
    int dur [N];

    initial begin
        logic [7:0] bounce;
        bounce = 8'b0111_0111;
        #1 rst_n = 1'b0;
        sw = 4'hF;
        tick(3);
        chk("reset_outputs", 32'({o_sw, o_p, o_r, o_h}), 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("reset_pre_latency", 32'(o_sw), 32'h0);
        tick(1);
        chk("reset_release_switch", 32'(o_sw), 32'hF);
        chk("reset_release_press", 32'(o_p), 32'hF);
        tick(1);
        chk("reset_press_one_cycle", 32'(o_p), 32'h0);
        sw = 4'h0;
        tick(6);
        chk("all_release", 32'(o_r), 32'hF);
        tick(4);

        sw[0] = 1'b1;
        tick(5);
        chk("ch0_before_latency", 32'(o_sw[0]), 32'd0);
        tick(1);
        chk("ch0_press", 32'({o_sw[0], o_p[0]}), 32'b11);
        tick(1);
        chk("ch0_press_ends", 32'(o_p[0]), 32'd0);
        sw[0] = 1'b0;
        tick(6);
        chk("ch0_release", 32'({o_sw[0], o_r[0]}), 32'b01);
        tick(4);

        for (int i = 0; i < 8; i++) begin
            sw[1] = bounce[i];
            tick(1);
            chk("ch1_bounce_quiet", 32'({o_sw[1], o_p[1], o_r[1]}), 32'd0);
        end
        sw[1] = 1'b1;
        tick(5);
        chk("ch1_bounce_tail", 32'(o_sw[1]), 32'd0);
        tick(1);
        chk("ch1_press", 32'(o_p[1]), 32'd1);
        sw[1] = 1'b0;
        tick(10);

        sw[2] = 1'b1;
        tick(6);
        chk("ch2_press", 32'(o_p[2]), 32'd1);
        cnt_h = 0;
        first_h = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (o_h[2]) begin
                cnt_h++;
                if (first_h == 0) first_h = i;
            end
        end
        chk("ch2_hold_count", 32'(cnt_h), 32'd1);
        chk("ch2_hold_delay", 32'(first_h), 32'd10);
        sw[2] = 1'b0;
        tick(6);
        chk("ch2_release", 32'(o_r[2]), 32'd1);
        tick(4);

        sw[3] = 1'b1;
        tick(6);
        chk("ch3_press", 32'(o_p[3]), 32'd1);
        tick(2);
        sw[3] = 1'b0;
        cnt_h = 0;
        cnt_r = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            cnt_h += int'(o_h[3]);
            cnt_r += int'(o_r[3]);
        end
        chk("ch3_no_hold", 32'(cnt_h), 32'd0);
        chk("ch3_release_count", 32'(cnt_r), 32'd1);

        sw[0] = 1'b1;
        tick(6);
        chk("rst_mid_press", 32'(o_p[0]), 32'd1);
        tick(5);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outputs", 32'({o_sw, o_p, o_r, o_h}), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("rst_mid_repress", 32'({o_sw[0], o_p[0]}), 32'b11);
        tick(9);
        chk("rst_mid_hold_early", 32'(o_h[0]), 32'd0);
        tick(1);
        chk("rst_mid_hold", 32'(o_h[0]), 32'd1);
        tick(1);
        chk("rst_mid_hold_once", 32'(o_h[0]), 32'd0);
        sw[0] = 1'b0;
        tick(10);

        for (int n = 0; n < N; n++) dur[n] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < N; n++) begin
                dur[n]--;
                if (dur[n] == 0) begin
                    sw[n] = ~sw[n];
                    dur[n] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 7);
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end else begin
                tick(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input-side companion to the LED blink top: conditions the board's raw push-button inputs for the rest of the design. Each switch passes through a two-flop synchronizer and a per-channel debounce counter. The block outputs clean levels plus single-cycle press, release and long-hold pulses. It sits directly behind the switch pins and feeds LED or control logic running on the 25 MHz `i_Clk`.

## Interface
- `g_NUM_SW`, default 4: number of independent switch channels.
- `g_DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required to accept a new level (10 ms at 25 MHz). Must be ≥ 2.
- `g_HOLD_LIMIT`, default 25000000: cycles a debounced press must persist before the hold pulse fires (1 s). Must be ≥ 2.
- `i_Clk`  in  1  system clock, 25 MHz.
- `i_Rst_L`  in  1  reset, asynchronous, active-low.
- `i_Switch`  in  g_NUM_SW  raw, asynchronous switch pins. Active-high: 1 = pressed.
- `o_Switch`  out  g_NUM_SW  debounced level per channel.
- `o_Press`  out  g_NUM_SW  one-cycle pulse on accepted 0→1.
- `o_Release`  out  g_NUM_SW  one-cycle pulse on accepted 1→0.
- `o_Hold`  out  g_NUM_SW  one-cycle pulse once per press after g_HOLD_LIMIT cycles held.

## Operation
- One clock, one asynchronous active-low reset. Channels are fully independent; all logic is replicated per channel.
- **Reset (`i_Rst_L` = 0):**
  - Clears both synchronizer flops, stable level, debounce counter, hold counter, hold-done flag and all outputs.
  - Every output reads 0 during and immediately after reset.
- **Synchronizer:** `i_Switch[n]` → sync1 → sync2. Only sync2 is used downstream.
- **Debounce counter** (width `$clog2(g_DEBOUNCE_LIMIT+1)`), evaluated every cycle:
  - sync2 == stable: counter ← 0.
  - sync2 != stable and counter < g_DEBOUNCE_LIMIT−1: counter ← counter+1.
  - sync2 != stable and counter == g_DEBOUNCE_LIMIT−1: stable ← sync2, counter ← 0.
  - A single matching sample at any point restarts the count (bounce rejection).
- **Output level:** `o_Switch[n]` = stable, registered.
- **Edge pulses:**
  - `o_Press[n]` is registered high in exactly the cycle stable first reads 1.
  - `o_Release[n]` is registered high in exactly the cycle stable first reads 0.
  - The two are never high simultaneously on one channel.
- **Hold detection** (counter width `$clog2(g_HOLD_LIMIT+1)`):
  - Counter clears while stable = 0 and increments while stable = 1.
  - When it reaches g_HOLD_LIMIT with hold-done = 0: `o_Hold[n]` pulses one cycle, hold-done ← 1, counter stops (saturates).
  - hold-done clears when stable returns to 0.
  - No auto-repeat: at most one hold pulse per press.
- **Reset mid-operation:**
  - Stable restarts at 0.
  - A switch held through reset release yields a fresh press after the full debounce latency, then hold after g_HOLD_LIMIT.
  - No pulse is generated by reset itself.

## Timing
- Let E0 be the first edge that samples a new level into sync1 and L = g_DEBOUNCE_LIMIT.
- Assuming the input stays constant:
  - sync2 updates at E1.
  - The counter sees its first mismatch at E2.
  - stable/`o_Switch` update at edge E(L+1).
- `o_Press`/`o_Release` are high for the cycle following E(L+1), coincident with the first cycle of the new `o_Switch` level.
- `o_Hold` is high for the cycle following the edge g_HOLD_LIMIT cycles after the press edge.
- If release is accepted before that, no hold pulse occurs.
- Input glitches shorter than L consecutive sync2 samples never change any output.

## Test plan
- **Reset values:** assert `i_Rst_L` = 0 with `i_Switch` = 4'hF, params L = 4 and g_HOLD_LIMIT = 10 → all outputs 0. Release reset → `o_Switch` = 4'hF and `o_Press` = 4'hF for one cycle, 6 edges after the first post-reset edge.
- **Clean press/release on channel 0:**
  - Drive `i_Switch[0]` 0→1 → `o_Switch[0]` rises after edge E5 with a coincident 1-cycle `o_Press[0]`.
  - Drop to 0 → 1-cycle `o_Release[0]` after the same 6-edge latency.
- **Bounce:** toggle `i_Switch[1]` with pattern 1,1,1,0,1,1,1,0 cycles, then hold 1 → no output activity during bouncing. `o_Press[1]` fires only after 4 consecutive high sync2 samples.
- **Long hold:** hold `i_Switch[2]` for 30 cycles past the press → exactly one `o_Hold[2]` pulse, 10 cycles after `o_Press[2]`, with no repeat. A release then yields `o_Release[2]`.
- **Short press:** hold `i_Switch[3]` for 8 cycles post-debounce → `o_Press[3]` and `o_Release[3]` fire, `o_Hold[3]` never fires.
- **Reset during hold count:** press channel 0, pull `i_Rst_L` low at hold count 5 → all outputs 0 immediately. After release with the switch still held: new `o_Press[0]` after 6 edges, `o_Hold[0]` 10 cycles later.
